// File: rtl/dds_pkg.sv
// Shared types and constants for the multi-channel DDS generator.
// DDS_DITHER_EN adds the LFSR constants used for phase dithering.
package dds_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    SAW    = 2'd1,
    SQUARE = 2'd2,
    TRI    = 2'd3
  } wave_mode_e;

  typedef enum logic [1:0] {
    SEL_FWORD = 2'd0,
    SEL_POFF  = 2'd1,
    SEL_MODE  = 2'd2,
    SEL_AMP   = 2'd3
  } cfg_sel_e;

  localparam logic [7:0] AMP_UNITY = 8'hFF;

`ifdef DDS_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
`endif

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: phase accumulator, offset, ROM-latency delay line,
// wave-shape mux and amplitude scaling stage.
module dds_channel
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int DAC_W   = 14,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] fword,
  input  logic [PHASE_W-1:0] poff,
  input  logic [PHASE_W-1:0] phase_dither,
  input  wave_mode_e         mode,
  input  logic [7:0]         amp,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DAC_W-1:0]   rom_q,
  output logic [DAC_W-1:0]   dac_data,
  output logic               wrap
);

  localparam int TRUNC_W = PHASE_W - ADDR_W;
  localparam int SAW_SH  = DAC_W - ADDR_W;
  localparam int TRI_SH  = DAC_W - ADDR_W + 1;
  localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

  logic [PHASE_W-1:0] acc;
  logic               wrap0;
  logic [PHASE_W:0]   acc_sum;
  logic [PHASE_W-1:0] phase;

  assign acc_sum = {1'b0, acc} + {1'b0, fword};
  assign phase   = acc + poff + phase_dither;

  // Carry out of the accumulator is only meaningful on cycles it advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      wrap0 <= 1'b0;
    end else if (phase_clr) begin
      acc   <= '0;
      wrap0 <= 1'b0;
    end else if (en) begin
      acc   <= acc_sum[PHASE_W-1:0];
      wrap0 <= acc_sum[PHASE_W];
    end else begin
      wrap0 <= 1'b0;
    end
  end

  wave_mode_e mode_p;
  logic [7:0] amp_p;
  logic       wrap_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      mode_p   <= SINE;
      amp_p    <= AMP_UNITY;
      wrap_p   <= 1'b0;
    end else begin
      rom_addr <= ADDR_W'(phase >> TRUNC_W);
      mode_p   <= mode;
      amp_p    <= amp;
      wrap_p   <= wrap0;
    end
  end

  // Sideband fields travel alongside the ROM access so they meet rom_q.
  logic [ADDR_W-1:0] addr_dl [ROM_LAT];
  wave_mode_e        mode_dl [ROM_LAT];
  logic [7:0]        amp_dl  [ROM_LAT];
  logic              wrap_dl [ROM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        addr_dl[i] <= '0;
        mode_dl[i] <= SINE;
        amp_dl[i]  <= AMP_UNITY;
        wrap_dl[i] <= 1'b0;
      end
    end else begin
      addr_dl[0] <= rom_addr;
      mode_dl[0] <= mode_p;
      amp_dl[0]  <= amp_p;
      wrap_dl[0] <= wrap_p;
      for (int i = 1; i < ROM_LAT; i++) begin
        addr_dl[i] <= addr_dl[i-1];
        mode_dl[i] <= mode_dl[i-1];
        amp_dl[i]  <= amp_dl[i-1];
        wrap_dl[i] <= wrap_dl[i-1];
      end
    end
  end

  logic [ADDR_W-1:0] addr_a;
  logic [DAC_W-1:0]  wave_next;

  assign addr_a = addr_dl[ROM_LAT-1];

  always_comb begin
    wave_next = rom_q;
    case (mode_dl[ROM_LAT-1])
      SINE:   wave_next = rom_q;
      SAW:    wave_next = DAC_W'(addr_a) << SAW_SH;
      SQUARE: wave_next = addr_a[ADDR_W-1] ? '1 : '0;
      TRI:    wave_next = DAC_W'(addr_a[ADDR_W-2:0] ^ {(ADDR_W-1){addr_a[ADDR_W-1]}}) << TRI_SH;
      default: wave_next = rom_q;
    endcase
  end

  logic [DAC_W-1:0] wave_w;
  logic [7:0]       amp_w;
  logic             wrap_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_w <= MID;
      amp_w  <= AMP_UNITY;
      wrap_w <= 1'b0;
    end else begin
      wave_w <= wave_next;
      amp_w  <= amp_dl[ROM_LAT-1];
      wrap_w <= wrap_dl[ROM_LAT-1];
    end
  end

  // Scale around mid-scale; the result stays inside the DAC range by construction.
  logic signed [DAC_W:0]   diff;
  logic signed [DAC_W+9:0] prod;
  logic [DAC_W-1:0]        scaled;

  assign diff   = $signed({1'b0, wave_w}) - $signed({1'b0, MID});
  assign prod   = diff * $signed({1'b0, amp_w});
  assign scaled = MID + DAC_W'(prod >>> 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_data <= MID;
      wrap     <= 1'b0;
    end else begin
      dac_data <= (amp_w == AMP_UNITY) ? wave_w : scaled;
      wrap     <= wrap_w;
    end
  end

endmodule

// File: rtl/dds_multi_gen.sv
// Multi-channel DDS top: configuration decode, shadow/active registers with
// atomic commit, and NCH channel instances. DDS_DITHER_EN enables phase dither.
module dds_multi_gen
  import dds_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int DAC_W   = 14,
  parameter int ROM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_ch,
  input  logic [1:0]            cfg_sel,
  input  logic [PHASE_W-1:0]    cfg_data,
  input  logic                  cfg_commit,
  input  logic                  cfg_phase_rst,
  output logic [NCH*ADDR_W-1:0] rom_addr,
  input  logic [NCH*DAC_W-1:0]  rom_q,
  output logic [NCH*DAC_W-1:0]  dac_data,
  output logic [NCH-1:0]        wrap
);

  logic [PHASE_W-1:0] fword_sh [NCH];
  logic [PHASE_W-1:0] poff_sh  [NCH];
  wave_mode_e         mode_sh  [NCH];
  logic [7:0]         amp_sh   [NCH];
  logic [PHASE_W-1:0] fword_act [NCH];
  logic [PHASE_W-1:0] poff_act  [NCH];
  wave_mode_e         mode_act  [NCH];
  logic [7:0]         amp_act   [NCH];

  logic phase_clr;
  assign phase_clr = cfg_commit & cfg_phase_rst;

  // Commit copies pre-edge shadows, so a same-cycle write only reaches the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        fword_sh[ch]  <= '0;
        poff_sh[ch]   <= '0;
        mode_sh[ch]   <= SINE;
        amp_sh[ch]    <= AMP_UNITY;
        fword_act[ch] <= '0;
        poff_act[ch]  <= '0;
        mode_act[ch]  <= SINE;
        amp_act[ch]   <= AMP_UNITY;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (cfg_commit) begin
          fword_act[ch] <= fword_sh[ch];
          poff_act[ch]  <= poff_sh[ch];
          mode_act[ch]  <= mode_sh[ch];
          amp_act[ch]   <= amp_sh[ch];
        end
        if (cfg_we && (int'(cfg_ch) == ch)) begin
          case (cfg_sel_e'(cfg_sel))
            SEL_FWORD: fword_sh[ch] <= cfg_data;
            SEL_POFF:  poff_sh[ch]  <= cfg_data;
            SEL_MODE:  mode_sh[ch]  <= wave_mode_e'(cfg_data[1:0]);
            SEL_AMP:   amp_sh[ch]   <= cfg_data[7:0];
            default:   fword_sh[ch] <= fword_sh[ch];
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [PHASE_W-1:0] dither;

`ifdef DDS_DITHER_EN
    localparam int TRUNC_W = PHASE_W - ADDR_W;
    localparam int DSH = (TRUNC_W >= 16) ? TRUNC_W - 16 : 0;
    localparam int DRS = (TRUNC_W >= 16) ? 0 : 16 - TRUNC_W;
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED + 16'(g);
      else     lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    // Dither lands in the truncated bits just below the ROM address.
    assign dither = PHASE_W'(lfsr >> DRS) << DSH;
`else
    assign dither = '0;
`endif

    dds_channel #(
      .PHASE_W (PHASE_W),
      .ADDR_W  (ADDR_W),
      .DAC_W   (DAC_W),
      .ROM_LAT (ROM_LAT)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .phase_clr    (phase_clr),
      .fword        (fword_act[g]),
      .poff         (poff_act[g]),
      .phase_dither (dither),
      .mode         (mode_act[g]),
      .amp          (amp_act[g]),
      .rom_addr     (rom_addr[g*ADDR_W +: ADDR_W]),
      .rom_q        (rom_q[g*DAC_W +: DAC_W]),
      .dac_data     (dac_data[g*DAC_W +: DAC_W]),
      .wrap         (wrap[g])
    );
  end

endmodule

// File: tb/tb_dds_multi_gen.sv
// Self-checking bench for dds_multi_gen: directed scenarios followed by random
// configuration traffic, checked every cycle against a behavioural model.
module tb_dds_multi_gen;

  localparam int NCH     = 2;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 12;
  localparam int DAC_W   = 14;
  localparam int ROM_LAT = 1;
  localparam int DEPTH   = ROM_LAT + 3;
  localparam int MID     = 8192;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic                  cfg_we = 1'b0;
  logic [2:0]            cfg_ch = '0;
  logic [1:0]            cfg_sel = '0;
  logic [PHASE_W-1:0]    cfg_data = '0;
  logic                  cfg_commit = 1'b0;
  logic                  cfg_phase_rst = 1'b0;
  logic [NCH*ADDR_W-1:0] rom_addr;
  logic [NCH*DAC_W-1:0]  rom_q;
  logic [NCH*DAC_W-1:0]  dac_data;
  logic [NCH-1:0]        wrap;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dds_multi_gen #(
    .NCH(NCH), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DAC_W(DAC_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_phase_rst(cfg_phase_rst), .rom_addr(rom_addr), .rom_q(rom_q),
    .dac_data(dac_data), .wrap(wrap)
  );

  // External sine ROM stand-in: returns addr + 0x100 after ROM_LAT cycles.
  logic [NCH*DAC_W-1:0] rom_dl [ROM_LAT];
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      rom_dl[0][c*DAC_W +: DAC_W] <= DAC_W'(rom_addr[c*ADDR_W +: ADDR_W]) + 14'h100;
    for (int i = 1; i < ROM_LAT; i++) rom_dl[i] <= rom_dl[i-1];
  end
  assign rom_q = rom_dl[ROM_LAT-1];

  function automatic int wave_of(input int mode, input int addr);
    case (mode)
      0: return (addr + 256) % 16384;
      1: return addr * 4;
      2: return (addr >= 2048) ? 16383 : 0;
      default: return (addr < 2048) ? addr * 8 : (4095 - addr) * 8;
    endcase
  endfunction

  function automatic int scale_of(input int w, input int amp);
    int d;
    if (amp == 255) return w;
    d = (w - MID) * amp;
    return MID + (d >>> 8);
  endfunction

  typedef struct {
    int addr;
    int mode;
    int amp;
    bit wrap;
    bit known;
  } ent_t;

  logic [31:0] m_acc [NCH];
  bit          m_wrap0 [NCH];
  logic [31:0] sh_fw [NCH];
  logic [31:0] sh_po [NCH];
  int          sh_mode [NCH];
  int          sh_amp [NCH];
  logic [31:0] act_fw [NCH];
  logic [31:0] act_po [NCH];
  int          act_mode [NCH];
  int          act_amp [NCH];
  ent_t        hist [NCH][DEPTH];
  bit          last_rst;

  // Model: what each edge must do, from the configuration and accumulator rules.
  always @(posedge clk) begin
    last_rst = rst;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; m_wrap0[c] = 0;
        sh_fw[c] = 0; sh_po[c] = 0; sh_mode[c] = 0; sh_amp[c] = 255;
        act_fw[c] = 0; act_po[c] = 0; act_mode[c] = 0; act_amp[c] = 255;
        for (int k = 0; k < DEPTH; k++) hist[c][k] = '{0, 0, 255, 1'b0, 1'b0};
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic [31:0] ph;
        logic [32:0] s;
        ph = m_acc[c] + act_po[c];
        for (int k = DEPTH - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = '{int'(ph >> 20), act_mode[c], act_amp[c], m_wrap0[c], 1'b1};
        s = {1'b0, m_acc[c]} + {1'b0, act_fw[c]};
        if (cfg_commit && cfg_phase_rst) begin
          m_acc[c] = 0; m_wrap0[c] = 0;
        end else if (en) begin
          m_acc[c] = s[31:0]; m_wrap0[c] = s[32];
        end else begin
          m_wrap0[c] = 0;
        end
        if (cfg_commit) begin
          act_fw[c] = sh_fw[c]; act_po[c] = sh_po[c];
          act_mode[c] = sh_mode[c]; act_amp[c] = sh_amp[c];
        end
        if (cfg_we && int'(cfg_ch) == c) begin
          case (cfg_sel)
            2'd0: sh_fw[c] = cfg_data;
            2'd1: sh_po[c] = cfg_data;
            2'd2: sh_mode[c] = int'(cfg_data[1:0]);
            default: sh_amp[c] = int'(cfg_data[7:0]);
          endcase
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every cycle, shortly after the active edge.
  always begin
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("rom_addr%0d", c), int'(rom_addr[c*ADDR_W +: ADDR_W]), hist[c][0].addr);
      checkOutput($sformatf("wrap%0d", c), int'(wrap[c]), int'(hist[c][DEPTH-1].wrap));
      if (last_rst)
        checkOutput($sformatf("dac_rst%0d", c), int'(dac_data[c*DAC_W +: DAC_W]), MID);
      else if (hist[c][DEPTH-1].known)
        checkOutput($sformatf("dac%0d", c), int'(dac_data[c*DAC_W +: DAC_W]),
                    scale_of(wave_of(hist[c][DEPTH-1].mode, hist[c][DEPTH-1].addr), hist[c][DEPTH-1].amp));
    end
  end

  task automatic applyStimulus(input bit we, input int ch, input int sel,
                               input logic [31:0] data, input bit commit, input bit prst);
    @(negedge clk);
    cfg_we = we;
    cfg_ch = 3'(ch);
    cfg_sel = 2'(sel);
    cfg_data = data;
    cfg_commit = commit;
    cfg_phase_rst = prst;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 0, 0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic writeCfg(input int ch, input int sel, input logic [31:0] data);
    applyStimulus(1'b1, ch, sel, data, 1'b0, 1'b0);
  endtask

  initial begin
    int a0;
    int a1;

    checkOutput("pin_amp80", scale_of('h3FFC, 'h80), 'h2FFE);
    checkOutput("pin_amp0", scale_of(5000, 0), 'h2000);
    checkOutput("pin_neg", scale_of(0, 128), 'h1000);
    checkOutput("pin_tri_q", wave_of(3, 1024), 'h2000);
    checkOutput("pin_tri_hi", wave_of(3, 3072), 'h1FF8);
    checkOutput("pin_square", wave_of(2, 2048), 'h3FFF);
    checkOutput("pin_saw", wave_of(1, 4095), 'h3FFC);
    checkOutput("pin_sine", wave_of(0, 4095), 'h10FF);

    rst = 1'b1;
    idleCycles(3);
    @(posedge clk); #2;
    checkOutput("reset_dac", int'(dac_data), 'h2000_2000 >> 2 << 2 == 0 ? 0 : int'({14'h2000, 14'h2000}));
    checkOutput("reset_addr", int'(rom_addr), 0);
    checkOutput("reset_wrap", int'(wrap), 0);
    rst = 1'b0;

    writeCfg(0, 0, 32'h0010_0000);
    writeCfg(0, 2, 32'd1);
    applyStimulus(1'b0, 0, 0, 32'h0, 1'b1, 1'b0);
    en = 1'b1;
    idleCycles(4200);

    writeCfg(1, 0, 32'h8000_0000);
    writeCfg(1, 2, 32'd2);
    applyStimulus(1'b0, 0, 0, 32'h0, 1'b1, 1'b0);
    idleCycles(20);

    writeCfg(0, 3, 32'h80);
    applyStimulus(1'b0, 0, 0, 32'h0, 1'b1, 1'b0);
    idleCycles(40);
    writeCfg(0, 3, 32'h00);
    applyStimulus(1'b0, 0, 0, 32'h0, 1'b1, 1'b0);
    idleCycles(10);

    writeCfg(0, 3, 32'hFF);
    writeCfg(1, 3, 32'hFF);
    writeCfg(0, 2, 32'd3);
    writeCfg(1, 2, 32'd3);
    writeCfg(1, 1, 32'h4000_0000);
    writeCfg(1, 0, 32'h0010_0000);
    writeCfg(5, 0, 32'hDEAD_BEEF);
    idleCycles(50);
    applyStimulus(1'b0, 0, 0, 32'h0, 1'b1, 1'b1);
    idleCycles(100);
    @(posedge clk); #2;
    a0 = int'(rom_addr[0 +: ADDR_W]);
    a1 = int'(rom_addr[ADDR_W +: ADDR_W]);
    checkOutput("tri_quarter_lead", (a1 - a0) & 4095, 1024);

    writeCfg(0, 2, 32'd0);
    writeCfg(1, 2, 32'd0);
    applyStimulus(1'b0, 0, 0, 32'h0, 1'b1, 1'b0);
    idleCycles(20);
    en = 1'b0;
    idleCycles(20);
    en = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      bit we;
      bit commit;
      bit prst;
      int sel;
      logic [31:0] data;
      we = ($urandom_range(2) == 0);
      commit = ($urandom_range(19) == 0);
      prst = ($urandom_range(1) == 0) && ($urandom_range(3) != 0);
      sel = $urandom_range(3);
      data = $urandom;
      if (sel == 3 && $urandom_range(2) == 0) data = 32'hFF;
      applyStimulus(we, $urandom_range(7), sel, data, commit, prst);
      en = ($urandom_range(7) != 0);
      rst = ($urandom_range(499) == 0);
    end
    rst = 1'b0;
    idleCycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
